// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-port register file with 1-cycle registered reads, a zero
//            register, and a per-register busy scoreboard for long-latency
//            producers. Optional macro REGFILE_BYPASS_EN forwards same-cycle
//            write data to matching reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                sb_set,
    input  logic [$clog2(NREGS)-1:0] sb_addr,
    output logic [NRD-1:0]      rd_busy,
    output logic                stall
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs     [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [XLEN-1:0]  r_rd_q     [NRD];
    logic [AW-1:0]    w_addr     [NRD];
    logic [XLEN-1:0]  w_val      [NRD];
    logic [NRD-1:0]   w_busy;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_port
            logic w_hit;
            assign w_addr[gi] = rd_addr[gi*AW +: AW];
            assign w_hit      = wr_en && (wr_addr == w_addr[gi]);
`ifdef REGFILE_BYPASS_EN
            assign w_val[gi]  = (w_addr[gi] == '0) ? '0 :
                                w_hit ? wr_data : r_regs[w_addr[gi]];
            assign w_busy[gi] = rd_en[gi] && (w_addr[gi] != '0) &&
                                r_busy[w_addr[gi]] && !w_hit;
`else
            // Without forwarding, a same-cycle write makes the array value stale.
            assign w_val[gi]  = (w_addr[gi] == '0) ? '0 : r_regs[w_addr[gi]];
            assign w_busy[gi] = rd_en[gi] && (w_addr[gi] != '0) &&
                                (r_busy[w_addr[gi]] || w_hit);
`endif
            assign rd_data[gi*XLEN +: XLEN] = r_rd_q[gi];
        end
    endgenerate

    assign rd_busy = w_busy;
    assign stall   = |w_busy;

    // A set and a clear on the same register resolve to set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wr_en) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (sb_set) begin
            w_busy_nxt[sb_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
            for (int p = 0; p < NRD; p++) begin
                r_rd_q[p] <= '0;
            end
        end else begin
            r_busy <= w_busy_nxt;
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    r_rd_q[p] <= w_val[p];
                end
            end
            if (wr_en && (wr_addr != '0)) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed and randomized checks of regfile_scoreboard against an
//            array-based reference model (4 read ports).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic [NRD-1:0]      rd_busy;
    logic                stall;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .rd_busy(rd_busy), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    logic [XLEN-1:0] m_rd   [NRD];
    logic [NRD-1:0]  last_busy;
    logic            last_stall;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic rd(input int port, input int addr);
        rd_en[port] = 1'b1;
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic wr(input int addr, input logic [XLEN-1:0] data);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    endtask

    // One clock: check combinational flags mid-cycle, advance model, check read data.
    task automatic step();
        logic [NRD-1:0] eb;
        int a;
        bit hit;
        @(negedge clk);
        for (int i = 0; i < NRD; i++) begin
            a   = int'(rd_addr[i*AW +: AW]);
            hit = wr_en && (int'(wr_addr) == a);
            eb[i] = rd_en[i] && (a != 0) && ((m_busy[a] && !hit) || (!BYP && hit));
        end
        last_busy  = rd_busy;
        last_stall = stall;
        check("rd_busy", rd_busy, eb);
        check("stall", stall, |eb);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin m_regs[k] = '0; m_busy[k] = 0; end
            for (int i = 0; i < NRD; i++) m_rd[i] = '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                a = int'(rd_addr[i*AW +: AW]);
                if (rd_en[i]) begin
                    if (a == 0) m_rd[i] = '0;
                    else if (BYP && wr_en && int'(wr_addr) == a) m_rd[i] = wr_data;
                    else m_rd[i] = m_regs[a];
                end
            end
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 0;
            end
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1;
        end
        #1;
        for (int i = 0; i < NRD; i++) check("rd_data", rd_data[i*XLEN +: XLEN], m_rd[i]);
    endtask

    initial begin
        for (int k = 0; k < NREGS; k++) begin m_regs[k] = '0; m_busy[k] = 0; end
        for (int i = 0; i < NRD; i++) m_rd[i] = '0;
        idle(); rst = 1'b1;
        @(posedge clk); #1;
        step();

        // Reset state reads zero with no stall
        idle(); rd(0, 5); rd(1, 5); step();
        check("r30_d0", rd_data[31:0], 32'h0);
        check("r30_d1", rd_data[63:32], 32'h0);
        check("r30_stall", last_stall, 1'b0);

        // Write then read; x0 stays zero
        idle(); wr(7, 32'hDEADBEEF); step();
        idle(); rd(0, 7); step();
        check("r31_x7", rd_data[31:0], 32'hDEADBEEF);
        idle(); wr(0, 32'h1234); step();
        idle(); rd(0, 0); step();
        check("r31_x0", rd_data[31:0], 32'h0);

        // Scoreboard set then cleared by write-back
        idle(); sb_set = 1'b1; sb_addr = 5'd3; step();
        idle(); rd(0, 3); step();
        check("r32_busy", last_busy[0], 1'b1);
        check("r32_stall", last_stall, 1'b1);
        idle(); rd(0, 3); wr(3, 32'h55); step();
        check("r32_wb_busy", last_busy[0], BYP ? 1'b0 : 1'b1);
        check("r32_wb_data", rd_data[31:0], BYP ? 32'h55 : 32'h0);

        // Same-cycle read/write collision
        idle(); rd(0, 9); wr(9, 32'hA5A5A5A5); step();
        check("r33_data", rd_data[31:0], BYP ? 32'hA5A5A5A5 : 32'h0);
        check("r33_stall", last_stall, !BYP);
        idle(); rd(0, 9); step();
        check("r33_reread", rd_data[31:0], 32'hA5A5A5A5);

        // Set wins over same-cycle clear
        idle(); sb_set = 1'b1; sb_addr = 5'd4; wr(4, 32'h11); step();
        idle(); rd(0, 4); step();
        check("r34_stall", last_stall, 1'b1);
        idle(); wr(4, 32'h22); step();
        idle(); rd(0, 4); step();
        check("r34_clear", last_stall, 1'b0);
        check("r34_data", rd_data[31:0], 32'h22);

        // Reset clears busy bits
        idle(); sb_set = 1'b1; sb_addr = 5'd6; step();
        idle(); rst = 1'b1; step();
        idle(); rd(0, 6); step();
        check("r35_stall", last_stall, 1'b0);
        check("r35_data", rd_data[31:0], 32'h0);

        // All ports on one address
        idle(); wr(8, 32'h77); step();
        idle(); for (int i = 0; i < NRD; i++) rd(i, 8); step();
        for (int i = 0; i < NRD; i++) check("r35_multi", rd_data[i*XLEN +: XLEN], 32'h77);

        // Randomized traffic over a narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 39) == 0);
            if (!rst) begin
                rd_en = NRD'($urandom);
                for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            end
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = $urandom;
            sb_set  = $urandom_range(0, 3) == 0;
            sb_addr = AW'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
